store_addr_gen: RTL and testbench



---
 rtl/store_addr_gen.sv | 115 +++++++++++
 tb/tb_store_addr_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_addr_gen.sv
// Burst start-address producer for the store_addr prefetch FIFO; rotates through c_FRAME_NUM frame buffers.
// Optional macro STORE_ADDR_FRAME_SKIP_EN adds rd_frame_idx and skips the frame held by the display side.
module store_addr_gen #(
    parameter int unsigned                c_ADDR_WIDTH  = 32,
    parameter logic [c_ADDR_WIDTH-1:0]    c_BASE_ADDR   = 32'h1000_0000,
    parameter logic [c_ADDR_WIDTH-1:0]    c_FRAME_BYTES = 32'h0010_0000,
    parameter logic [c_ADDR_WIDTH-1:0]    c_BURST_BYTES = 32'd256,
    parameter int unsigned                c_FRAME_NUM   = 3,
    parameter int unsigned                c_PEND_WIDTH  = 4
) (
    input  logic                    wr_clk,
    input  logic                    wr_rst,
    input  logic                    frame_start,
    input  logic                    burst_req,
    output logic [c_ADDR_WIDTH-1:0] wr_data,
    output logic                    wr_en,
    input  logic                    wr_vld,
    output logic [2:0]              frame_idx,
    output logic                    frame_done,
    output logic                    pend_ovf
`ifdef STORE_ADDR_FRAME_SKIP_EN
    ,
    input  logic [2:0]              rd_frame_idx
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [c_ADDR_WIDTH-1:0] LAST_OFF  = c_FRAME_BYTES - c_BURST_BYTES;
    localparam logic [2:0]              LAST_IDX  = 3'(c_FRAME_NUM - 1);
    localparam logic [c_PEND_WIDTH-1:0] PEND_ONE  = c_PEND_WIDTH'(1);

    logic [1:0]              state, nxt_state;
    logic [c_ADDR_WIDTH-1:0] offset, nxt_off;
    logic [c_PEND_WIDTH-1:0] pend, nxt_pend;
    logic [2:0]              nxt_idx, adv_idx, inc1_idx;
    logic                    nxt_ovf, nxt_done, push;
    logic [c_ADDR_WIDTH-1:0] nxt_addr;

    // frame_start masks wr_en so a truncating restart never pushes a stale address
    assign wr_en = (state == S_RUN) && (pend != '0) && !frame_start;
    assign push  = wr_en && wr_vld;

    assign inc1_idx = (frame_idx == LAST_IDX) ? 3'd0 : frame_idx + 3'd1;
`ifdef STORE_ADDR_FRAME_SKIP_EN
    assign adv_idx = (inc1_idx != rd_frame_idx) ? inc1_idx :
                     (inc1_idx == LAST_IDX) ? 3'd0 : inc1_idx + 3'd1;
`else
    assign adv_idx = inc1_idx;
`endif

    always_comb begin
        nxt_state = state;
        nxt_idx   = frame_idx;
        nxt_off   = offset;
        nxt_pend  = pend;
        nxt_ovf   = pend_ovf;
        nxt_done  = 1'b0;
        if (frame_start) begin
            nxt_state = S_RUN;
            nxt_off   = '0;
            nxt_pend  = burst_req ? PEND_ONE : '0;
            if (state != S_IDLE)
                nxt_idx = adv_idx;
        end else if (state == S_RUN) begin
            if (burst_req && !push) begin
                if (pend == '1)
                    nxt_ovf = 1'b1;
                else
                    nxt_pend = pend + PEND_ONE;
            end else if (!burst_req && push) begin
                nxt_pend = pend - PEND_ONE;
            end
            if (push) begin
                if (offset == LAST_OFF) begin
                    nxt_state = S_DONE;
                    nxt_off   = '0;
                    nxt_done  = 1'b1;
                end else begin
                    nxt_off = offset + c_BURST_BYTES;
                end
            end
        end else if (burst_req) begin
            nxt_ovf = 1'b1;
        end
    end

    // address built from next-state values so wr_data tracks idx/offset with no extra cycle
    assign nxt_addr = c_BASE_ADDR
                    + ({{(c_ADDR_WIDTH-3){1'b0}}, nxt_idx} * c_FRAME_BYTES)
                    + nxt_off;

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state      <= S_IDLE;
            frame_idx  <= 3'd0;
            offset     <= '0;
            pend       <= '0;
            pend_ovf   <= 1'b0;
            frame_done <= 1'b0;
            wr_data    <= c_BASE_ADDR;
        end else begin
            state      <= nxt_state;
            frame_idx  <= nxt_idx;
            offset     <= nxt_off;
            pend       <= nxt_pend;
            pend_ovf   <= nxt_ovf;
            frame_done <= nxt_done;
            wr_data    <= nxt_addr;
        end
    end

endmodule

// File: tb/tb_store_addr_gen.sv
// Directed bench for store_addr_gen: vector table for the basic frame plus hand sequences for corner cases.
module tb_store_addr_gen;

    logic        clk = 1'b0;
    logic        wr_rst, frame_start, burst_req, wr_vld;
    logic [31:0] wr_data;
    logic        wr_en, frame_done, pend_ovf;
    logic [2:0]  frame_idx;
`ifdef STORE_ADDR_FRAME_SKIP_EN
    logic [2:0]  rd_frame_idx = 3'd7;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [31:0] pushq[$];

    always #5 clk = ~clk;

    store_addr_gen #(
        .c_ADDR_WIDTH (32),
        .c_BASE_ADDR  (32'h1000_0000),
        .c_FRAME_BYTES(32'd1024),
        .c_BURST_BYTES(32'd256),
        .c_FRAME_NUM  (3),
        .c_PEND_WIDTH (4)
    ) dut (
        .wr_clk     (clk),
        .wr_rst     (wr_rst),
        .frame_start(frame_start),
        .burst_req  (burst_req),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .wr_vld     (wr_vld),
        .frame_idx  (frame_idx),
        .frame_done (frame_done),
        .pend_ovf   (pend_ovf)
`ifdef STORE_ADDR_FRAME_SKIP_EN
        ,
        .rd_frame_idx(rd_frame_idx)
`endif
    );

    typedef struct {
        logic        fs, br, vld;
        logic        en;
        logic [31:0] data;
        logic [2:0]  idx;
        logic        done, ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // one cycle: drive at negedge, sample 1ns later, record any push
    task automatic step(input logic fs, input logic br, input logic vld);
        @(negedge clk);
        frame_start = fs;
        burst_req   = br;
        wr_vld      = vld;
        #1;
        if (wr_en && wr_vld) pushq.push_back(wr_data);
        if (frame_done) done_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_rst = 1'b1; frame_start = 1'b0; burst_req = 1'b0; wr_vld = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        wr_rst = 1'b0;
        pushq.delete();
        done_cnt = 0;
    endtask

    initial begin
        logic [2:0] exp_idx;
        wr_rst = 1'b1; frame_start = 1'b0; burst_req = 1'b0; wr_vld = 1'b0;

        //            fs    br    vld   en    data           idx   done  ovf
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h1000_0000, 3'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0000, 3'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h1000_0000, 3'd0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h1000_0000, 3'd0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h1000_0100, 3'd0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h1000_0200, 3'd0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h1000_0300, 3'd0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h1000_0000, 3'd0, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h1000_0000, 3'd0, 1'b0, 1'b0};

        // basic frame
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].fs, vecs[i].br, vecs[i].vld);
            chk($sformatf("basic[%0d].wr_en", i),      32'(wr_en),      32'(vecs[i].en));
            chk($sformatf("basic[%0d].wr_data", i),    wr_data,         vecs[i].data);
            chk($sformatf("basic[%0d].frame_idx", i),  32'(frame_idx),  32'(vecs[i].idx));
            chk($sformatf("basic[%0d].frame_done", i), 32'(frame_done), 32'(vecs[i].done));
            chk($sformatf("basic[%0d].pend_ovf", i),   32'(pend_ovf),   32'(vecs[i].ovf));
        end
        chk("basic.push_cnt", 32'(pushq.size()), 32'd4);
        for (int k = 0; k < pushq.size() && k < 4; k++)
            chk($sformatf("basic.addr[%0d]", k), pushq[k], 32'h1000_0000 + 32'(k) * 32'h100);
        chk("basic.done_cnt", 32'(done_cnt), 32'd1);

        // rotation through frames 1, 2, then wrap to 0
        for (int f = 1; f <= 3; f++) begin
            exp_idx = 3'(f % 3);
            pushq.delete();
            step(1'b1, 1'b0, 1'b1);
            step(1'b0, 1'b1, 1'b1);
            chk($sformatf("rot%0d.frame_idx", f), 32'(frame_idx), 32'(exp_idx));
            repeat (3) step(1'b0, 1'b1, 1'b1);
            repeat (3) step(1'b0, 1'b0, 1'b1);
            chk($sformatf("rot%0d.push_cnt", f), 32'(pushq.size()), 32'd4);
            for (int k = 0; k < pushq.size() && k < 4; k++)
                chk($sformatf("rot%0d.addr[%0d]", f, k), pushq[k],
                    32'h1000_0000 + 32'(exp_idx) * 32'h400 + 32'(k) * 32'h100);
        end
        chk("rot.done_cnt", 32'(done_cnt), 32'd4);

        // backpressure: three requests held while FIFO is full
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b0, 1'b0);
            chk($sformatf("bp[%0d].wr_en", c),   32'(wr_en), 32'd1);
            chk($sformatf("bp[%0d].wr_data", c), wr_data,    32'h1000_0000);
        end
        repeat (3) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("bp.wr_en_after", 32'(wr_en), 32'd0);
        chk("bp.push_cnt", 32'(pushq.size()), 32'd3);
        for (int k = 0; k < pushq.size() && k < 3; k++)
            chk($sformatf("bp.addr[%0d]", k), pushq[k], 32'h1000_0000 + 32'(k) * 32'h100);
        chk("bp.pend_ovf", 32'(pend_ovf), 32'd0);

        // request in IDLE is illegal
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("idle_req.pend_ovf", 32'(pend_ovf), 32'd1);

        // pending counter saturates at 15; 16th request is dropped
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        repeat (15) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("ovf15.pend_ovf", 32'(pend_ovf), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("ovf16.pend_ovf", 32'(pend_ovf), 32'd1);
        chk("ovf16.wr_en", 32'(wr_en), 32'd1);

        // reset mid-frame with pend_ovf set and wr_en high
        @(negedge clk);
        wr_rst = 1'b1;
        @(negedge clk);
        wr_rst = 1'b0;
        #1;
        chk("rst.wr_en",      32'(wr_en),      32'd0);
        chk("rst.wr_data",    wr_data,         32'h1000_0000);
        chk("rst.frame_idx",  32'(frame_idx),  32'd0);
        chk("rst.frame_done", 32'(frame_done), 32'd0);
        chk("rst.pend_ovf",   32'(pend_ovf),   32'd0);
        step(1'b0, 1'b0, 1'b1);
        chk("rst.wr_en_next", 32'(wr_en), 32'd0);

        // truncation: restart with two pending bursts
        pushq.delete();
        done_cnt = 0;
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("trunc.wr_en_pend", 32'(wr_en), 32'd1);
        step(1'b1, 1'b0, 1'b1);
        chk("trunc.wr_en_masked", 32'(wr_en), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        chk("trunc.wr_en_cleared", 32'(wr_en), 32'd0);
        chk("trunc.frame_idx", 32'(frame_idx), 32'd1);
        chk("trunc.wr_data", wr_data, 32'h1000_0400);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("trunc.push_cnt", 32'(pushq.size()), 32'd1);
        if (pushq.size() > 0) chk("trunc.addr", pushq[0], 32'h1000_0400);
        chk("trunc.done_cnt", 32'(done_cnt), 32'd0);

        // frame_start and burst_req together: exactly one push at the new base
        pushq.delete();
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("same.frame_idx", 32'(frame_idx), 32'd2);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("same.push_cnt", 32'(pushq.size()), 32'd1);
        if (pushq.size() > 0) chk("same.addr", pushq[0], 32'h1000_0800);

        // frame skip around the display-held buffer
        do_reset();
`ifdef STORE_ADDR_FRAME_SKIP_EN
        rd_frame_idx = 3'd1;
`endif
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
`ifdef STORE_ADDR_FRAME_SKIP_EN
        chk("skip.frame_idx", 32'(frame_idx), 32'd2);
        chk("skip.wr_data", wr_data, 32'h1000_0800);
`else
        chk("noskip.frame_idx", 32'(frame_idx), 32'd1);
        chk("noskip.wr_data", wr_data, 32'h1000_0400);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
